packet_rx_assembler: RTL and testbench
======================================

# packet_rx_assembler

Upstream framing stage for `ethernet_interface`: it accepts a byte-serial receive stream with valid/ready/last handshaking and assembles MSB-first bytes into one `PACKET_WIDTH`-bit command word of the form {header, addr, data}. It rejects frames with a bad header or a wrong length. It presents good packets as a held word plus a one-cycle `packet_valid` pulse, spaced so the downstream 3-state controller never misses one.

## Interface
- `ADDR_WIDTH`, default 8: address field width.
- `DATA_WIDTH`, default 32: data field width.
- `PACKET_WIDTH`, default 8+ADDR_WIDTH+DATA_WIDTH: output word width; must be a multiple of 8. NUM_BYTES = PACKET_WIDTH/8, which is 6 at the defaults.
- `MIN_GAP`, default 3, minimum 1: minimum number of cycles between consecutive `packet_valid` pulses.
- `clk` in 1: the single clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `rx_data` in 8: stream byte.
- `rx_valid` in 1: byte present.
- `rx_last` in 1: byte is the last of its frame.
- `rx_ready` out 1: byte accepted when `rx_valid && rx_ready` at a rising edge.
- `packet_in` out PACKET_WIDTH: assembled packet; held stable until the next good packet.
- `packet_valid` out 1: one-cycle pulse per good packet.
- `frame_error` out 1: one-cycle pulse per rejected frame.
- `ok_count` out 16: good frames, saturating.
- `err_count` out 16: rejected frames, saturating.

## Operation
- **Reset values:** state HDR, `rx_ready` 0, `packet_in` 0, `packet_valid` 0, `frame_error` 0, both counters 0, byte count 0, gap counter 0.
- Reset mid-frame or mid-EMIT discards the partial frame silently. No error pulse and no count.
- `rx_ready` is registered: it equals (next state != EMIT). It goes to 1 on the first edge after reset release.
- Bytes shift into an internal PACKET_WIDTH shift register, MSB-first. The first byte becomes bits [PACKET_WIDTH-1:PACKET_WIDTH-8].
- **HDR** (waiting for the first byte), on an accepted byte:
  - Byte is 8'hAA or 8'hBB: shift it in and set byte count to 1.
  - If `rx_last` is also set, it is a short frame: error, stay in HDR. Otherwise go to BODY.
  - Any other header byte: error. If `rx_last` is set, stay in HDR; otherwise go to DISCARD.
- **BODY**, on an accepted byte: shift it in and increment the byte count.
  - Byte count reaches NUM_BYTES with `rx_last`: go to EMIT.
  - Byte count reaches NUM_BYTES without `rx_last`: long-frame error, go to DISCARD.
  - Byte count below NUM_BYTES with `rx_last`: short-frame error, go to HDR.
- **DISCARD:** accept and drop bytes. On an accepted byte with `rx_last`, go to HDR. No further error is raised for this frame.
- **EMIT:** `rx_ready` is 0.
  - On the first edge where the gap counter is 0: load `packet_in` from the shift register, assert `packet_valid`, increment `ok_count`, load gap counter with MIN_GAP-1, go to HDR.
  - Otherwise, wait in EMIT.
- **Gap counter:** decrements each cycle while non-zero and stops at 0.
- **Error handling:** `frame_error` pulses on the edge where the error is detected, and `err_count` increments on that same edge. Exactly one error is counted per bad frame.
- **Counters:** both hold at 16'hFFFF instead of wrapping.
- `packet_in` changes only on an EMIT load. Rejected frames never disturb it.
- Bytes with `rx_valid` low are ignored in every state. `rx_last` is only meaningful on an accepted byte.

## Timing
- **Latency:** last byte accepted at edge N. With the gap counter at 0, `packet_in` and `packet_valid` update at edge N+1. `packet_valid` is high for exactly one cycle.
- **Back-to-back frames:** `rx_ready` is low for exactly the cycle(s) spent in EMIT. With the defaults (NUM_BYTES 6, MIN_GAP 3), EMIT lasts one cycle, so throughput is 6 bytes per 7 cycles.
- **Pulse spacing:** a pulse at edge E means the next pulse can come no earlier than edge E+MIN_GAP. This matches the downstream IDLE→PROCESS→RESPOND→IDLE loop at MIN_GAP=3.
- **Gap interaction:** if the gap counter is non-zero on entry to EMIT, the emit is delayed and `rx_ready` stays low until it completes.
- The error pulse and the counter update happen on the same edge. A frame never produces both `packet_valid` and `frame_error`.

## Test plan
- **Good write frame:** send BB 12 DE AD BE EF with `rx_last` on EF. Expect `packet_in`=48'hBB12DEADBEEF, a single `packet_valid` pulse one cycle after the last byte, `ok_count`=1, `rx_ready` low for 1 cycle.
- **Bad header:** send frame 55 01 02 03 04 05 (last on 05), then AA 34 00 00 00 00. Expect one `frame_error` and `err_count`=1. `packet_in` stays 0 until the AA frame emits 48'hAA3400000000.
- **Short and long frames:** send AA 01 02 (last), then BB with 7 bytes (last on the 7th). Expect `err_count`=2, no `packet_valid`, and the error pulse for the long frame exactly at its 6th byte.
- **Gap enforcement:** MIN_GAP=10, with two good 6-byte frames fed with `rx_valid` constantly high. Expect the pulses exactly 10 cycles apart and `rx_ready` low while the second frame waits in EMIT.
- **Reset mid-frame:** send 3 bytes of a good frame, pulse `rst_n` low asynchronously between edges. Expect all outputs at their reset values immediately. Then a fresh good frame emits correctly with `ok_count`=1.
- **Saturation:** force or run `err_count` to 16'hFFFE and send 2 bad frames. Expect it to reach 16'hFFFF and hold there.

Source files
------------

// File: rtl/packet_rx_assembler.sv
// Byte-serial receive framer: assembles MSB-first bytes into one command word,
// rejects bad header/length frames and spaces good-packet pulses by MIN_GAP.
module packet_rx_assembler #(
    parameter int ADDR_WIDTH   = 8,
    parameter int DATA_WIDTH   = 32,
    parameter int PACKET_WIDTH = 8 + ADDR_WIDTH + DATA_WIDTH,
    parameter int MIN_GAP      = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [7:0]              rx_data,
    input  logic                    rx_valid,
    input  logic                    rx_last,
    output logic                    rx_ready,
    output logic [PACKET_WIDTH-1:0] packet_in,
    output logic                    packet_valid,
    output logic                    frame_error,
    output logic [15:0]             ok_count,
    output logic [15:0]             err_count
);
    localparam int NUM_BYTES = PACKET_WIDTH / 8;
    localparam int CW        = $clog2(NUM_BYTES + 1);
    localparam int GW        = (MIN_GAP > 1) ? $clog2(MIN_GAP) : 1;

    typedef enum logic [1:0] {S_HDR, S_BODY, S_DISCARD, S_EMIT} state_e;

    state_e                  state_q, state_d;
    logic [PACKET_WIDTH-1:0] shift_q, shift_d;
    logic [PACKET_WIDTH-1:0] pkt_q, pkt_d;
    logic [CW-1:0]           cnt_q, cnt_d, cnt_inc;
    logic [GW-1:0]           gap_q, gap_d;
    logic                    rdy_q;
    logic                    pv_q, pv_d;
    logic                    fe_q, fe_d;
    logic [15:0]             ok_q, err_q;
    logic                    acc;
    logic [PACKET_WIDTH-1:0] shift_in;

    assign acc      = rx_valid && rdy_q;
    assign cnt_inc  = cnt_q + 1'b1;
    assign shift_in = (shift_q << 8) | PACKET_WIDTH'(rx_data);

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        pkt_d   = pkt_q;
        cnt_d   = cnt_q;
        pv_d    = 1'b0;
        fe_d    = 1'b0;
        gap_d   = (gap_q != '0) ? gap_q - 1'b1 : gap_q;
        case (state_q)
            S_HDR: begin
                if (acc) begin
                    if (rx_data == 8'hAA || rx_data == 8'hBB) begin
                        shift_d = shift_in;
                        cnt_d   = CW'(1);
                        if (rx_last) fe_d = 1'b1;
                        else         state_d = S_BODY;
                    end else begin
                        fe_d = 1'b1;
                        if (!rx_last) state_d = S_DISCARD;
                    end
                end
            end
            S_BODY: begin
                if (acc) begin
                    shift_d = shift_in;
                    cnt_d   = cnt_inc;
                    if (cnt_inc == CW'(NUM_BYTES)) begin
                        if (rx_last) begin
                            state_d = S_EMIT;
                        end else begin
                            fe_d    = 1'b1;
                            state_d = S_DISCARD;
                        end
                    end else if (rx_last) begin
                        fe_d    = 1'b1;
                        state_d = S_HDR;
                    end
                end
            end
            S_DISCARD: begin
                // the frame's error was already counted when it was detected
                if (acc && rx_last) state_d = S_HDR;
            end
            S_EMIT: begin
                if (gap_q == '0) begin
                    pkt_d   = shift_q;
                    pv_d    = 1'b1;
                    gap_d   = GW'(MIN_GAP - 1);
                    state_d = S_HDR;
                end
            end
            default: state_d = S_HDR;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_HDR;
            shift_q <= '0;
            pkt_q   <= '0;
            cnt_q   <= '0;
            gap_q   <= '0;
            rdy_q   <= 1'b0;
            pv_q    <= 1'b0;
            fe_q    <= 1'b0;
            ok_q    <= '0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            pkt_q   <= pkt_d;
            cnt_q   <= cnt_d;
            gap_q   <= gap_d;
            rdy_q   <= (state_d != S_EMIT);
            pv_q    <= pv_d;
            fe_q    <= fe_d;
            if (pv_d && ok_q != 16'hFFFF)  ok_q  <= ok_q + 16'd1;
            if (fe_d && err_q != 16'hFFFF) err_q <= err_q + 16'd1;
        end
    end

    assign rx_ready     = rdy_q;
    assign packet_in    = pkt_q;
    assign packet_valid = pv_q;
    assign frame_error  = fe_q;
    assign ok_count     = ok_q;
    assign err_count    = err_q;
endmodule

// File: tb/tb_packet_rx_assembler.sv
// Scoreboard bench for packet_rx_assembler: default instance plus a MIN_GAP=10
// instance for pulse-spacing checks.
module tb_packet_rx_assembler;
    localparam int PW = 48;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [7:0]    rx_data = 8'h00;
    logic          rx_valid = 1'b0, rx_last = 1'b0;
    logic          rdy_a, pv_a, fe_a, rdy_b, pv_b, fe_b;
    logic [PW-1:0] pk_a, pk_b;
    logic [15:0]   ok_a, er_a, ok_b, er_b;
    logic          sel = 1'b0;
    logic          rdy, pv, fe;
    logic [PW-1:0] pk;
    logic [15:0]   okc, erc;

    assign rdy = sel ? rdy_b : rdy_a;
    assign pv  = sel ? pv_b  : pv_a;
    assign fe  = sel ? fe_b  : fe_a;
    assign pk  = sel ? pk_b  : pk_a;
    assign okc = sel ? ok_b  : ok_a;
    assign erc = sel ? er_b  : er_a;

    packet_rx_assembler u_a (
        .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_last(rx_last), .rx_ready(rdy_a), .packet_in(pk_a),
        .packet_valid(pv_a), .frame_error(fe_a), .ok_count(ok_a), .err_count(er_a));

    packet_rx_assembler #(.MIN_GAP(10)) u_b (
        .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_last(rx_last), .rx_ready(rdy_b), .packet_in(pk_b),
        .packet_valid(pv_b), .frame_error(fe_b), .ok_count(ok_b), .err_count(er_b));

    int n_vec = 0, n_err = 0;
    int cyc = 0, last_pv = 0, prev_pv = 0, fe_cnt = 0;
    logic [PW-1:0] exp_q[$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // scoreboard: every packet_valid pops and compares the oldest expected word
    always @(negedge clk) begin
        if (rst_n) begin
            if (pv) begin
                chk("sb_pkt_expected", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) chk("sb_pkt", 64'(pk), 64'(exp_q.pop_front()));
                prev_pv = last_pv;
                last_pv = cyc;
            end
            if (fe) fe_cnt++;
        end
    end

    task automatic send_byte(input logic [7:0] b, input logic last);
        rx_data = b; rx_valid = 1'b1; rx_last = last;
        for (int i = 0; i < 100; i++) begin
            if (rdy) begin
                @(posedge clk); #1;
                return;
            end
            @(posedge clk); #1;
        end
        chk("ready_timeout", 64'(rdy), 64'd1);
    endtask

    task automatic send_frame(input logic [63:0] w, input int n);
        for (int i = 0; i < n; i++)
            send_byte(w[8*(n-1-i) +: 8], i == n - 1);
    endtask

    task automatic idle();
        rx_valid = 1'b0; rx_last = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        exp_q.delete();
        fe_cnt = 0;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        #12;
        chk("rst_rdy", 64'(rdy_a), 0);
        chk("rst_pkt", 64'(pk_a), 0);
        chk("rst_pv", 64'(pv_a), 0);
        chk("rst_fe", 64'(fe_a), 0);
        chk("rst_ok", 64'(ok_a), 0);
        chk("rst_err", 64'(er_a), 0);
        do_reset();
        chk("rdy_after_rst", 64'(rdy_a), 1);

        // good write frame, latency and one-cycle pulse
        exp_q.push_back(48'hBB12DEADBEEF);
        send_frame(64'hBB12DEADBEEF, 6); idle();
        chk("emit_rdy_low", 64'(rdy), 0);
        chk("pv_early", 64'(pv), 0);
        @(posedge clk); #1;
        chk("pv_latency", 64'(pv), 1);
        chk("good_pkt", 64'(pk), 64'h BB12DEADBEEF);
        chk("good_ok", 64'(okc), 1);
        chk("rdy_back", 64'(rdy), 1);
        @(posedge clk); #1;
        chk("pv_one_cycle", 64'(pv), 0);

        // bad header then good frame
        send_byte(8'h55, 1'b0);
        chk("hdr_err_pulse", 64'(fe), 1);
        chk("hdr_err_cnt", 64'(erc), 1);
        send_frame(64'h0102030405, 5); idle();
        chk("discard_no_err", 64'(erc), 1);
        chk("pkt_undisturbed", 64'(pk), 64'hBB12DEADBEEF);
        exp_q.push_back(48'hAA3400000000);
        send_frame(64'hAA3400000000, 6); idle();
        repeat (2) @(posedge clk); #1;
        chk("hdr_next_pkt", 64'(pk), 64'hAA3400000000);
        chk("hdr_next_ok", 64'(okc), 2);

        // short frame, then long frame
        send_frame(64'hAA0102, 3);
        chk("short_err", 64'(fe), 1);
        chk("short_cnt", 64'(erc), 2);
        send_byte(8'hBB, 1'b0);
        for (int i = 1; i < 5; i++) send_byte(8'(i), 1'b0);
        chk("long_no_err_yet", 64'(fe), 0);
        send_byte(8'h05, 1'b0);
        chk("long_err_at_6th", 64'(fe), 1);
        chk("long_cnt", 64'(erc), 3);
        send_byte(8'h06, 1'b1); idle();
        chk("long_single_err", 64'(fe), 0);
        @(posedge clk); #1;
        chk("long_cnt_hold", 64'(erc), 3);
        chk("err_no_pkt", 64'(okc), 2);
        chk("fe_pulses", 64'(fe_cnt), 3);

        // back-to-back default throughput
        exp_q.push_back(48'h AA0011223344);
        exp_q.push_back(48'h BB5566778899);
        send_frame(64'hAA0011223344, 6);
        send_frame(64'hBB5566778899, 6); idle();
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        chk("b2b_spacing", 64'(last_pv - prev_pv), 7);
        chk("b2b_ok", 64'(okc), 4);

        // asynchronous reset mid-frame
        send_byte(8'hBB, 1'b0); send_byte(8'h12, 1'b0); send_byte(8'hDE, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("amid_rdy", 64'(rdy_a), 0);
        chk("amid_pkt", 64'(pk_a), 0);
        chk("amid_ok", 64'(ok_a), 0);
        chk("amid_err", 64'(er_a), 0);
        chk("amid_pv_fe", 64'({pv_a, fe_a}), 0);
        do_reset();
        exp_q.push_back(48'hBBCAFE001234);
        send_frame(64'hBBCAFE001234, 6); idle();
        repeat (2) @(posedge clk); #1;
        chk("post_rst_pkt", 64'(pk), 64'hBBCAFE001234);
        chk("post_rst_ok", 64'(okc), 1);
        chk("post_rst_err", 64'(erc), 0);

        // error counter saturation
        force u_a.err_q = 16'hFFFE;
        #1 release u_a.err_q;
        #1 chk("sat_preload", 64'(er_a), 16'hFFFE);
        send_byte(8'h55, 1'b1);
        chk("sat_reach", 64'(er_a), 16'hFFFF);
        send_byte(8'h66, 1'b1); idle();
        chk("sat_hold", 64'(er_a), 16'hFFFF);
        chk("sat_fe", 64'(fe_a), 1);

        // gap enforcement on the MIN_GAP=10 instance
        do_reset();
        sel = 1'b1;
        exp_q.push_back(48'hAA0102030405);
        exp_q.push_back(48'hBB0A0B0C0D0E);
        send_frame(64'hAA0102030405, 6);
        send_frame(64'hBB0A0B0C0D0E, 6); idle();
        chk("gap_rdy_low", 64'(rdy), 0);
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            if (pv) break;
            chk("gap_wait_rdy", 64'(rdy), 0);
        end
        @(negedge clk); #1;
        chk("gap_spacing", 64'(last_pv - prev_pv), 10);
        chk("gap_ok", 64'(okc), 2);
        chk("gap_pkt", 64'(pk), 64'hBB0A0B0C0D0E);

        chk("sb_drained", 64'(exp_q.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
